usb_status_seq: RTL and testbench

USB_STATUS_SEQ -- requirements
Module: usb_status_seq

---
 rtl/usb_status_seq_pkg.sv | 32 +++
 rtl/usb_status_fifo.sv | 60 ++++++
 rtl/usb_status_seq.sv | 153 +++++++++++++++
 tb/tb_usb_status_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_status_seq_pkg.sv
// Shared types, state encodings and default sizing for the status update sequencer.
package usb_status_seq_pkg;

   localparam int unsigned DEF_DEPTH       = 4;
   localparam int unsigned DEF_HOLD_CYCLES = 2;
   localparam int unsigned DEF_GAP_CYCLES  = 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSetup = 2'd1,
      StHold  = 2'd2,
      StGap   = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic [7:0] set_bits;
      logic [7:0] reset_bits;
   } status_entry_t;

   // Build one FIFO entry from the MCU and SNES sides; SNES never clears bits.
   function automatic status_entry_t merge_req(input logic       mcu_req,
                                               input logic [7:0] mcu_set,
                                               input logic [7:0] mcu_reset,
                                               input logic       snes_evt,
                                               input logic [7:0] snes_set);
      status_entry_t e;
      e.set_bits   = (mcu_req ? mcu_set : 8'h00) | (snes_evt ? snes_set : 8'h00);
      e.reset_bits = mcu_req ? mcu_reset : 8'h00;
      return e;
   endfunction

endpackage

// File: rtl/usb_status_fifo.sv
// Synchronous DEPTH x 16 FIFO for queued status requests; head is visible combinationally.
module usb_status_fifo
   import usb_status_seq_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic          clkin,
   input  logic          rst_n,
   input  logic          push,
   input  status_entry_t push_data,
   input  logic          pop,
   output status_entry_t pop_data,
   output logic          full,
   output logic          empty,
   output logic [3:0]    level
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   status_entry_t  mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [3:0]      level_q;
   logic            do_push;
   logic            do_pop;

   assign full     = (level_q == 4'(DEPTH));
   assign empty    = (level_q == 4'd0);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];

   // A push into a full FIFO only lands when a pop frees the slot this cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage array, no reset needed since level gates visibility.
   always_ff @(posedge clkin) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= 4'd0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= PtrW'(wr_ptr_q + 1'b1);
         end
         if (do_pop) begin
            rd_ptr_q <= PtrW'(rd_ptr_q + 1'b1);
         end
         level_q <= level_q + {3'b000, do_push} - {3'b000, do_pop};
      end
   end

endmodule

// File: rtl/usb_status_seq.sv
// Merges MCU/SNES status requests into a FIFO and replays them as timed we pulses.
module usb_status_seq
   import usb_status_seq_pkg::*;
#(
   parameter int unsigned DEPTH       = DEF_DEPTH,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       mcu_req,
   input  logic [7:0] mcu_set_bits,
   input  logic [7:0] mcu_reset_bits,
   output logic       mcu_ack,
   input  logic       snes_evt,
   input  logic [7:0] snes_set_bits,
   input  logic       ovf_clr,
   output logic [7:0] status_set_bits,
   output logic [7:0] status_reset_bits,
   output logic       status_reset_we,
   output logic [3:0] fifo_level,
   output logic       overflow,
   output logic       busy
);

   seq_state_e    state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    set_q, set_d;
   logic [7:0]    rst_q, rst_d;
   logic          we_q, we_d;
   logic          ack_q;
   logic          ovf_q;
   logic          busy_q;

   status_entry_t push_entry;
   status_entry_t head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [3:0]    level;
   logic [3:0]    level_nxt;
   logic          pop;
   logic          push_req;
   logic          accept;
   logic          push_ok;
   logic          drop;

   assign push_req   = mcu_req || snes_evt;
   assign accept     = !fifo_full || pop;
   assign push_ok    = push_req && accept;
   assign drop       = snes_evt && !accept;
   assign push_entry = merge_req(mcu_req, mcu_set_bits, mcu_reset_bits, snes_evt, snes_set_bits);
   assign level_nxt  = level + {3'b000, push_ok} - {3'b000, pop};

   usb_status_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clkin     (clkin),
      .rst_n     (rst_n),
      .push      (push_ok),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (level)
   );

   // Next-state: pop in IDLE, then SETUP, HOLD_CYCLES of HOLD, GAP_CYCLES of GAP.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      set_d   = set_q;
      rst_d   = rst_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               set_d   = head.set_bits;
               rst_d   = head.reset_bits;
               state_d = StSetup;
            end
         end
         StSetup: begin
            cnt_d   = 8'd0;
            state_d = StHold;
         end
         StHold: begin
            if (cnt_q == 8'(HOLD_CYCLES - 1)) begin
               cnt_d   = 8'd0;
               state_d = StGap;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StGap: begin
            if (cnt_q == 8'(GAP_CYCLES - 1)) begin
               cnt_d   = 8'd0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      we_d = (state_d == StHold);
   end

   // FSM, mask and strobe registers.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         set_q   <= 8'h00;
         rst_q   <= 8'h00;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         set_q   <= set_d;
         rst_q   <= rst_d;
         we_q    <= we_d;
      end
   end

   // Ack, sticky overflow (a new drop beats ovf_clr) and busy.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         ack_q  <= 1'b0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         ack_q  <= mcu_req && accept;
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
         busy_q <= (state_d != StIdle) || (level_nxt != 4'd0);
      end
   end

   assign mcu_ack           = ack_q;
   assign status_set_bits   = set_q;
   assign status_reset_bits = rst_q;
   assign status_reset_we   = we_q;
   assign fifo_level        = level;
   assign overflow          = ovf_q;
   assign busy              = busy_q;

endmodule

// File: tb/tb_usb_status_seq.sv
// Randomized and directed bench for usb_status_seq against a timeline-based reference model.
module tb_usb_status_seq;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned HOLD  = 2;
   localparam int unsigned GAP   = 2;

   logic       clkin = 1'b0;
   logic       rst_n = 1'b0;
   logic       mcu_req = 1'b0;
   logic [7:0] mcu_set_bits = 8'h00;
   logic [7:0] mcu_reset_bits = 8'h00;
   logic       mcu_ack;
   logic       snes_evt = 1'b0;
   logic [7:0] snes_set_bits = 8'h00;
   logic       ovf_clr = 1'b0;
   logic [7:0] status_set_bits;
   logic [7:0] status_reset_bits;
   logic       status_reset_we;
   logic [3:0] fifo_level;
   logic       overflow;
   logic       busy;

   usb_status_seq #(
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clkin             (clkin),
      .rst_n             (rst_n),
      .mcu_req           (mcu_req),
      .mcu_set_bits      (mcu_set_bits),
      .mcu_reset_bits    (mcu_reset_bits),
      .mcu_ack           (mcu_ack),
      .snes_evt          (snes_evt),
      .snes_set_bits     (snes_set_bits),
      .ovf_clr           (ovf_clr),
      .status_set_bits   (status_set_bits),
      .status_reset_bits (status_reset_bits),
      .status_reset_we   (status_reset_we),
      .fifo_level        (fifo_level),
      .overflow          (overflow),
      .busy              (busy)
   );

   always #5 clkin = ~clkin;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: queue of pending entries plus the age of the entry being replayed.
   logic [15:0] mq[$];
   bit          m_inflight = 0;
   int          m_age = 0;
   logic [7:0]  m_set = 8'h00;
   logic [7:0]  m_rst = 8'h00;
   bit          m_ack = 0;
   bit          m_ovf = 0;

   // Observation helpers.
   logic        we_prev = 1'b0;
   int          low_run = 0;
   bit          seen_pulse = 0;
   int          pulse_cnt = 0;
   logic [7:0]  bank = 8'h00;
   logic [7:0]  last_set = 8'h00;
   logic [7:0]  last_rst = 8'h00;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [15:0] e;
      bit pop, acc, drop;
      if (!rst_n) begin
         mq.delete();
         m_inflight = 0;
         m_age = 0;
         m_set = 8'h00;
         m_rst = 8'h00;
         m_ack = 0;
         m_ovf = 0;
      end else begin
         pop = !m_inflight && (mq.size() > 0);
         acc = (mq.size() < DEPTH) || pop;
         if (pop) begin
            e = mq.pop_front();
            m_set = e[15:8];
            m_rst = e[7:0];
            m_inflight = 1;
            m_age = 0;
         end else if (m_inflight) begin
            m_age++;
            if (m_age == 1 + HOLD + GAP) m_inflight = 0;
         end
         if ((mcu_req || snes_evt) && acc)
            mq.push_back({(mcu_req ? mcu_set_bits : 8'h00) | (snes_evt ? snes_set_bits : 8'h00),
                          (mcu_req ? mcu_reset_bits : 8'h00)});
         m_ack = mcu_req && acc;
         drop = snes_evt && !acc;
         if (drop) m_ovf = 1;
         else if (ovf_clr) m_ovf = 0;
      end
   endtask

   task automatic tick();
      bit exp_we;
      @(posedge clkin);
      model_step();
      #1;
      exp_we = m_inflight && (m_age >= 1) && (m_age <= HOLD);
      check_eq("ack", 16'(mcu_ack), 16'(m_ack));
      check_eq("we", 16'(status_reset_we), 16'(exp_we));
      check_eq("set_mask", 16'(status_set_bits), 16'(m_set));
      check_eq("reset_mask", 16'(status_reset_bits), 16'(m_rst));
      check_eq("level", 16'(fifo_level), 16'(mq.size()));
      check_eq("overflow", 16'(overflow), 16'(m_ovf));
      check_eq("busy", 16'(busy), 16'(m_inflight || (mq.size() > 0)));
      if (!rst_n) begin
         seen_pulse = 0;
         low_run = 0;
      end else if (status_reset_we && !we_prev) begin
         if (seen_pulse) check_eq("we_gap_ok", 16'(low_run >= GAP + 1), 16'd1);
         seen_pulse = 1;
         pulse_cnt++;
         bank = (bank & ~status_reset_bits) | status_set_bits;
         last_set = status_set_bits;
         last_rst = status_reset_bits;
      end else if (!status_reset_we) begin
         low_run++;
      end
      if (status_reset_we) low_run = 0;
      we_prev = status_reset_we;
   endtask

   task automatic drive(input logic req, input logic [7:0] s, input logic [7:0] r,
                        input logic evt, input logic [7:0] ss, input logic clr);
      mcu_req = req;
      mcu_set_bits = s;
      mcu_reset_bits = r;
      snes_evt = evt;
      snes_set_bits = ss;
      ovf_clr = clr;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      int p0;
      bit got_ack;
      bit found;

      // Reset state.
      rst_n = 1'b0;
      idle(2);
      check_eq("rst_level", 16'(fifo_level), 16'd0);
      check_eq("rst_we", 16'(status_reset_we), 16'd0);
      rst_n = 1'b1;
      idle(3);

      // Single MCU request: ack, masks, two-cycle we, bank reads 05.
      bank = 8'h00;
      drive(1'b1, 8'h05, 8'h00, 1'b0, 8'h00, 1'b0);
      check_eq("single_ack", 16'(mcu_ack), 16'd1);
      idle(1);
      check_eq("single_mask", 16'({status_set_bits, status_reset_bits}), 16'h0500);
      check_eq("single_setup_we", 16'(status_reset_we), 16'd0);
      idle(1);
      check_eq("single_we1", 16'(status_reset_we), 16'd1);
      idle(1);
      check_eq("single_we2", 16'(status_reset_we), 16'd1);
      idle(6);
      check_eq("single_bank", 16'(bank), 16'h0005);

      // Same-cycle MCU and SNES: one merged pulse.
      p0 = pulse_cnt;
      drive(1'b1, 8'h01, 8'h80, 1'b1, 8'h10, 1'b0);
      idle(10);
      check_eq("merge_pulses", 16'(pulse_cnt - p0), 16'd1);
      check_eq("merge_masks", 16'({last_set, last_rst}), 16'h1180);

      // Five SNES events while busy: fifth overflows, ovf_clr clears it.
      p0 = pulse_cnt;
      drive(1'b1, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 8'h00, 1'b1, 8'(8'h20 + i), 1'b0);
      check_eq("ovf_set", 16'(overflow), 16'd1);
      check_eq("ovf_level", 16'(fifo_level), 16'd4);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
      check_eq("ovf_clr", 16'(overflow), 16'd0);
      idle(45);
      check_eq("ovf_pulses", 16'(pulse_cnt - p0), 16'd5);

      // FIFO full: request held until the IDLE pop frees a slot.
      drive(1'b1, 8'h40, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h41 + i), 8'h00, 1'b0, 8'h00, 1'b0);
      check_eq("full_level", 16'(fifo_level), 16'd4);
      got_ack = 0;
      for (int i = 0; i < 40 && !got_ack; i++) begin
         drive(1'b1, 8'h4f, 8'h01, 1'b0, 8'h00, 1'b0);
         got_ack = mcu_ack;
      end
      check_eq("full_ack", 16'(got_ack), 16'd1);
      check_eq("full_level_kept", 16'(fifo_level), 16'd4);
      idle(50);

      // Reset in the second HOLD cycle with two entries queued.
      for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h60 + i), 8'h00, 1'b0, 8'h00, 1'b0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_inflight && m_age == 2) found = 1;
         else idle(1);
      end
      check_eq("midhold_found", 16'(found), 16'd1);
      check_eq("midhold_queued", 16'(fifo_level), 16'd2);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check_eq("midhold_we", 16'(status_reset_we), 16'd0);
      check_eq("midhold_level", 16'(fifo_level), 16'd0);
      check_eq("midhold_masks", 16'({status_set_bits, status_reset_bits}), 16'h0000);
      check_eq("midhold_busy", 16'(busy), 16'd0);
      idle(2);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         drive(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0),
               8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
      end
      rst_n = 1'b1;
      idle(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
